// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter and its load-result FIFO.
package wb_pkg;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_req_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_load_fifo.sv
// Load-result FIFO: one push per cycle, up to two pops per cycle, with head and head+1 peeks.
module wb_load_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  wb_req_t       push_req,
    input  logic [1:0]    pop_n,
    output wb_req_t       head,
    output wb_req_t       head1,
    output logic [CW-1:0] count,
    output logic          ready
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr1;
    logic [4:0]    mem_rd   [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic          push_ok;

    // ready depends on registered count only, so a same-cycle pop never frees a slot
    assign ready   = (count != CW'(DEPTH));
    assign push_ok = push && ready;
    assign rd_ptr1 = rd_ptr + AW'(1);

    assign head  = '{valid: (count != '0),       rd: mem_rd[rd_ptr],  data: mem_data[rd_ptr]};
    assign head1 = '{valid: (count > CW'(1)),    rd: mem_rd[rd_ptr1], data: mem_data[rd_ptr1]};

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_rd[wr_ptr]   <= push_req.rd;
            mem_data[wr_ptr] <= push_req.data;
        end
    end

    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr + AW'(pop_n);
            count  <= count + CW'(push_ok) - CW'(pop_n);
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) CW'(pop_n) <= count);

endmodule

// File: rtl/writeback_arbiter.sv
// Merges two ALU lanes and buffered load results onto the register file's two write ports.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          alu0_valid,
    input  logic [4:0]    alu0_rd,
    input  logic [31:0]   alu0_data,
    input  logic          alu1_valid,
    input  logic [4:0]    alu1_rd,
    input  logic [31:0]   alu1_data,
    input  logic          ld_valid,
    input  logic [4:0]    ld_rd,
    input  logic [31:0]   ld_data,
    output logic          ld_ready,
    output logic          reg_write,
    output logic [4:0]    regd,
    output logic [31:0]   write_data,
    output logic          reg_write2,
    output logic [4:0]    regd2,
    output logic [31:0]   write_data2,
    output logic [CW-1:0] ld_pending
);

    wb_req_t    head;
    wb_req_t    head1;
    wb_req_t    port1;
    wb_req_t    port2;
    wb_req_t    push_req;
    logic [1:0] pop_n;
    logic       push;
    logic       a0v;
    logic       a1v;

    // x0 loads still complete the handshake but are dropped instead of enqueued
    assign push     = ld_valid && ld_ready && (ld_rd != REG_ZERO);
    assign push_req = '{valid: 1'b1, rd: ld_rd, data: ld_data};

    assign a0v = alu0_valid && (alu0_rd != REG_ZERO);
    assign a1v = alu1_valid && (alu1_rd != REG_ZERO);

    wb_load_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_req (push_req),
        .pop_n    (pop_n),
        .head     (head),
        .head1    (head1),
        .count    (ld_pending),
        .ready    (ld_ready)
    );

    // Port 2 always gets the younger candidate; the register file gives it priority on equal rd
    always_comb begin
        port1 = '0;
        port2 = '0;
        pop_n = 2'd0;
        if (a0v) begin
            port1 = '{valid: 1'b1, rd: alu0_rd, data: alu0_data};
        end else if (head.valid) begin
            port1 = head;
            pop_n = 2'd1;
        end
        if (a1v) begin
            port2 = '{valid: 1'b1, rd: alu1_rd, data: alu1_data};
        end else if (pop_n == 2'd1) begin
            if (head1.valid) begin
                port2 = head1;
                pop_n = 2'd2;
            end
        end else if (head.valid) begin
            port2 = head;
            pop_n = 2'd1;
        end
        if (!en)
            pop_n = 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write   <= 1'b0;
            regd        <= '0;
            write_data  <= '0;
            reg_write2  <= 1'b0;
            regd2       <= '0;
            write_data2 <= '0;
        end else if (en) begin
            reg_write   <= port1.valid;
            regd        <= port1.rd;
            write_data  <= port1.data;
            reg_write2  <= port2.valid;
            regd2       <= port2.rd;
            write_data2 <= port2.data;
        end
    end

endmodule
